// File: rtl/alu_operand_ctrl_pkg.sv
// ============================================================================
// Module : alu_operand_ctrl_pkg
// Brief  : Shared widths, ALU opcodes and FSM encoding for alu_operand_ctrl.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package alu_operand_ctrl_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_XNOR = 3'b011;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_SUB  = 3'b101;
    localparam logic [2:0] OP_SLT  = 3'b110;
    localparam logic [2:0] OP_SLL  = 3'b111;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_LOAD = 2'd1;
    localparam state_t ST_EXEC = 2'd2;
    localparam state_t ST_WB   = 2'd3;

endpackage

`default_nettype wire

// File: rtl/alu_operand_ctrl_if.sv
// ============================================================================
// Module : alu_operand_ctrl_if
// Brief  : Operand/result bundle between the sequencer (master) and the ALU.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface alu_operand_ctrl_if
    import alu_operand_ctrl_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);
    logic [DATA_W-1:0] A;
    logic [DATA_W-1:0] B;
    logic [2:0]        ALU_OP;
    logic [DATA_W-1:0] F;
    logic              ZF;
    logic              OF;

    modport master (output A, output B, output ALU_OP, input F, input ZF, input OF);
    modport slave  (input A, input B, input ALU_OP, output F, output ZF, output OF);
endinterface

`default_nettype wire

// File: rtl/alu_operand_ctrl_regfile.sv
// ============================================================================
// Module : alu_regfile
// Brief  : 2^ADDR_W x DATA_W registers, r0 reads zero; two captured read
//          ports, one combinational debug read, one write port.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module alu_regfile
    import alu_operand_ctrl_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              we_i,
    input  wire logic [ADDR_W-1:0] waddr_i,
    input  wire logic [DATA_W-1:0] wdata_i,
    input  wire logic              cap_i,
    input  wire logic [ADDR_W-1:0] raddr_a_i,
    input  wire logic [ADDR_W-1:0] raddr_b_i,
    output logic      [DATA_W-1:0] rdata_a_o,
    output logic      [DATA_W-1:0] rdata_b_o,
    input  wire logic [ADDR_W-1:0] dbg_addr_i,
    output logic      [DATA_W-1:0] dbg_data_o
);
    localparam int NREGS = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] rd_a_d;
    logic [DATA_W-1:0] rd_b_d;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else if (we_i && (waddr_i != '0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        rd_a_d     = (raddr_a_i  == '0) ? '0 : regs_q[raddr_a_i];
        rd_b_d     = (raddr_b_i  == '0) ? '0 : regs_q[raddr_b_i];
        dbg_data_o = (dbg_addr_i == '0) ? '0 : regs_q[dbg_addr_i];
    end

    // Captured operands hold between operations so the ALU output stays stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
        end else if (cap_i) begin
            a_q <= rd_a_d;
            b_q <= rd_b_d;
        end
    end

    assign rdata_a_o = a_q;
    assign rdata_b_o = b_q;

endmodule

`default_nettype wire

// File: rtl/alu_operand_ctrl.sv
// ============================================================================
// Module : alu_operand_ctrl
// Brief  : IDLE/LOAD/EXEC/WB sequencer feeding a combinational ALU from a
//          programmable register file and writing the result back.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module alu_operand_ctrl
    import alu_operand_ctrl_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              start,
    input  wire logic [ADDR_W-1:0] R_Addr_A,
    input  wire logic [ADDR_W-1:0] R_Addr_B,
    input  wire logic [ADDR_W-1:0] W_Addr,
    input  wire logic [2:0]        OP_in,
    input  wire logic              init_we,
    input  wire logic [ADDR_W-1:0] init_addr,
    input  wire logic [DATA_W-1:0] init_data,
    alu_operand_ctrl_if.master     alu,
    output logic      [DATA_W-1:0] F_q,
    output logic                   ZF_q,
    output logic                   OF_q,
    output logic                   busy,
    output logic                   done,
    input  wire logic [ADDR_W-1:0] DBG_Addr,
    output logic      [DATA_W-1:0] DBG_Data
);
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ra_q, rb_q, rd_q;
    logic [2:0]        op_q, alu_op_q;
    logic [DATA_W-1:0] f_res_q;
    logic              zf_res_q, of_res_q, done_q;

    logic              accept, cap_en, exec_en, wb_en;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [DATA_W-1:0] rf_a, rf_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_LOAD;
            ST_LOAD: state_d = ST_EXEC;
            ST_EXEC: state_d = ST_WB;
            ST_WB:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy    = (state_q != ST_IDLE);
        accept  = (state_q == ST_IDLE) && start;
        cap_en  = (state_q == ST_LOAD);
        exec_en = (state_q == ST_EXEC);
        wb_en   = (state_q == ST_WB);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ra_q     <= '0;
            rb_q     <= '0;
            rd_q     <= '0;
            op_q     <= OP_AND;
            alu_op_q <= OP_AND;
            f_res_q  <= '0;
            zf_res_q <= 1'b0;
            of_res_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= wb_en;
            if (accept) begin
                ra_q <= R_Addr_A;
                rb_q <= R_Addr_B;
                rd_q <= W_Addr;
                op_q <= OP_in;
            end
            if (cap_en) alu_op_q <= op_q;
            if (exec_en) begin
                f_res_q  <= alu.F;
                zf_res_q <= alu.ZF;
                of_res_q <= alu.OF;
            end
        end
    end

    // Write-back and preload never coincide: preload is only honoured in IDLE.
    always_comb begin
        if (wb_en) begin
            rf_we    = (rd_q != '0);
            rf_waddr = rd_q;
            rf_wdata = f_res_q;
        end else begin
            rf_we    = (state_q == ST_IDLE) && init_we && (init_addr != '0);
            rf_waddr = init_addr;
            rf_wdata = init_data;
        end
    end

    alu_regfile #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_regfile (
        .clk        (clk),
        .rst_n      (rst_n),
        .we_i       (rf_we),
        .waddr_i    (rf_waddr),
        .wdata_i    (rf_wdata),
        .cap_i      (cap_en),
        .raddr_a_i  (ra_q),
        .raddr_b_i  (rb_q),
        .rdata_a_o  (rf_a),
        .rdata_b_o  (rf_b),
        .dbg_addr_i (DBG_Addr),
        .dbg_data_o (DBG_Data)
    );

    assign alu.A      = rf_a;
    assign alu.B      = rf_b;
    assign alu.ALU_OP = alu_op_q;
    assign F_q        = f_res_q;
    assign ZF_q       = zf_res_q;
    assign OF_q       = of_res_q;
    assign done       = done_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_operand_ctrl.sv
// ============================================================================
// Module : tb_alu_operand_ctrl
// Brief  : Self-checking bench: directed table, corner sequences, random ops.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_alu_operand_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  R_Addr_A = '0, R_Addr_B = '0, W_Addr = '0;
    logic [2:0]  OP_in = '0;
    logic        init_we = 1'b0;
    logic [4:0]  init_addr = '0;
    logic [31:0] init_data = '0;
    logic [31:0] F_q;
    logic        ZF_q, OF_q, busy, done;
    logic [4:0]  DBG_Addr = '0;
    logic [31:0] DBG_Data;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] ref_mem [32];

    alu_operand_ctrl_if alu_if ();

    alu_operand_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .R_Addr_A(R_Addr_A), .R_Addr_B(R_Addr_B), .W_Addr(W_Addr), .OP_in(OP_in),
        .init_we(init_we), .init_addr(init_addr), .init_data(init_data),
        .alu(alu_if.master),
        .F_q(F_q), .ZF_q(ZF_q), .OF_q(OF_q), .busy(busy), .done(done),
        .DBG_Addr(DBG_Addr), .DBG_Data(DBG_Data)
    );

    always #5 clk = ~clk;

    // Returns {OF, ZF, F} for a 32-bit ALU.
    function automatic logic [33:0] alu_fn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] f;
        logic        o;
        o = 1'b0;
        case (op)
            3'b000: f = a & b;
            3'b001: f = a | b;
            3'b010: f = a ^ b;
            3'b011: f = ~(a ^ b);
            3'b100: begin f = a + b; o = (a[31] == b[31]) && (f[31] != a[31]); end
            3'b101: begin f = a - b; o = (a[31] != b[31]) && (f[31] != a[31]); end
            3'b110: f = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: f = a << b[4:0];
        endcase
        return {o, (f == 32'd0), f};
    endfunction

    always_comb begin
        {alu_if.OF, alu_if.ZF, alu_if.F} = alu_fn(alu_if.ALU_OP, alu_if.A, alu_if.B);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic dbg_chk(input string name, input logic [4:0] addr, input logic [31:0] exp);
        DBG_Addr = addr;
        #1;
        chk(name, DBG_Data, exp);
    endtask

    task automatic preload(input logic [4:0] addr, input logic [31:0] data);
        init_we = 1'b1; init_addr = addr; init_data = data;
        @(negedge clk);
        init_we = 1'b0;
        if (addr != 0) ref_mem[addr] = data;
    endtask

    // Caller is at a negedge with the DUT able to accept; returns at the negedge
    // where done is high. glitch re-pulses start and init_we while busy.
    task automatic run_op(input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rd,
                          input logic [2:0] op, input bit glitch);
        logic [31:0] ea, eb;
        logic [33:0] res;
        int cnt;
        ea  = (ra == 0) ? 32'd0 : ref_mem[ra];
        eb  = (rb == 0) ? 32'd0 : ref_mem[rb];
        res = alu_fn(op, ea, eb);
        start = 1'b1; R_Addr_A = ra; R_Addr_B = rb; W_Addr = rd; OP_in = op;
        @(negedge clk);
        start = 1'b0; init_we = 1'b0;
        chk("busy_in_load", {31'd0, busy}, 32'd1);
        cnt = 0;
        while (!done && cnt < 10) begin
            if (glitch && cnt == 0) begin
                start = 1'b1; R_Addr_A = ~ra; R_Addr_B = ~rb; W_Addr = 5'd13; OP_in = ~op;
                init_we = 1'b1; init_addr = 5'd11; init_data = 32'hDEADBEEF;
            end
            @(negedge clk);
            start = 1'b0; init_we = 1'b0;
            cnt++;
        end
        chk("done_latency", cnt, 32'd3);
        chk("busy_in_done", {31'd0, busy}, 32'd0);
        chk("A_hold", alu_if.A, ea);
        chk("B_hold", alu_if.B, eb);
        chk("ALU_OP_hold", {29'd0, alu_if.ALU_OP}, {29'd0, op});
        chk("F_q", F_q, res[31:0]);
        chk("ZF_q", {31'd0, ZF_q}, {31'd0, res[32]});
        chk("OF_q", {31'd0, OF_q}, {31'd0, res[33]});
        if (rd != 0) ref_mem[rd] = res[31:0];
        dbg_chk("wb_reg", rd, (rd == 0) ? 32'd0 : ref_mem[rd]);
    endtask

    typedef struct {
        logic [4:0]  ra, rb, rd;
        logic [2:0]  op;
        logic [31:0] exp_f;
        logic        exp_z, exp_o;
    } vec_t;

    vec_t tbl [4];

    initial begin
        int dones;
        for (int i = 0; i < 32; i++) ref_mem[i] = 32'd0;
        tbl[0] = '{5'd1, 5'd2, 5'd3, 3'b100, 32'h0000060A, 1'b0, 1'b0};
        tbl[1] = '{5'd4, 5'd4, 5'd5, 3'b100, 32'hFFFFFFFE, 1'b0, 1'b1};
        tbl[2] = '{5'd1, 5'd1, 5'd6, 3'b010, 32'h00000000, 1'b1, 1'b0};
        tbl[3] = '{5'd1, 5'd2, 5'd0, 3'b001, 32'h00000607, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_A", alu_if.A, 32'd0);
        chk("rst_B", alu_if.B, 32'd0);
        chk("rst_ALU_OP", {29'd0, alu_if.ALU_OP}, 32'd0);
        chk("rst_F_q", F_q, 32'd0);
        chk("rst_flags", {30'd0, ZF_q, OF_q}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table
        preload(5'd1, 32'h00000003);
        preload(5'd2, 32'h00000607);
        preload(5'd4, 32'h7FFFFFFF);
        preload(5'd0, 32'hFFFFFFFF);
        dbg_chk("r0_preload_ignored", 5'd0, 32'd0);
        for (int i = 0; i < 4; i++) begin
            run_op(tbl[i].ra, tbl[i].rb, tbl[i].rd, tbl[i].op, 1'b0);
            chk("tbl_F", F_q, tbl[i].exp_f);
            chk("tbl_ZF", {31'd0, ZF_q}, {31'd0, tbl[i].exp_z});
            chk("tbl_OF", {31'd0, OF_q}, {31'd0, tbl[i].exp_o});
            dbg_chk("tbl_rd", tbl[i].rd, (tbl[i].rd == 0) ? 32'd0 : tbl[i].exp_f);
            @(negedge clk);
        end

        // Back-to-back in the done cycle, with a start/preload pulsed while busy
        run_op(5'd1, 5'd2, 5'd7, 3'b100, 1'b0);
        run_op(5'd7, 5'd1, 5'd8, 3'b101, 1'b1);
        dbg_chk("b2b_r8", 5'd8, 32'h00000607);
        dbg_chk("busy_preload_r11", 5'd11, 32'd0);
        dbg_chk("ignored_rd_r13", 5'd13, 32'd0);
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("no_extra_done", dones, 32'd0);

        // Same-cycle preload and start
        init_we = 1'b1; init_addr = 5'd9; init_data = 32'h12345678;
        ref_mem[9] = 32'h12345678;
        run_op(5'd9, 5'd0, 5'd10, 3'b001, 1'b0);
        dbg_chk("same_cycle_r10", 5'd10, 32'h12345678);
        @(negedge clk);

        // Reset during EXEC aborts the operation
        start = 1'b1; R_Addr_A = 5'd1; R_Addr_B = 5'd2; W_Addr = 5'd12; OP_in = 3'b100;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("exec_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) ref_mem[i] = 32'd0;
        for (int i = 0; i < 32; i++) dbg_chk("abort_reg_clear", i[4:0], 32'd0);
        chk("abort_A", alu_if.A, 32'd0);
        chk("abort_B", alu_if.B, 32'd0);
        chk("abort_F_q", F_q, 32'd0);
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        chk("abort_no_done", dones, 32'd0);

        // Randomised operations against the register-array model
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                logic [31:0] d;
                case ($urandom_range(0, 3))
                    0: d = 32'h7FFFFFFF;
                    1: d = 32'h80000000;
                    default: d = $urandom;
                endcase
                preload(5'($urandom_range(0, 31)), d);
            end
            run_op(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                   5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)), 1'b0);
        end
        for (int i = 0; i < 32; i++) dbg_chk("final_reg", i[4:0], ref_mem[i]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/alu_operand_ctrl.md
Name: alu_operand_ctrl

Overview:
Sequencer and register file that sits directly upstream of the combinational 32-bit ALU and also consumes its result.
- Holds 32 x 32-bit general registers, with r0 hardwired to zero.
- On a start pulse, reads two source registers and presents them as A/B with ALU_OP to the ALU.
- Captures F/ZF/OF, then writes F back to a destination register.
- Replaces the fixed switch-selected operand table with programmable operands.

Parameters:
DATA_W, 32, operand/result width (ALU is fixed at 32; not to be changed).
ADDR_W, 5, register address width (2**ADDR_W registers).

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  single-cycle request to execute one operation; sampled only in IDLE.
R_Addr_A  in  ADDR_W  source register for operand A; captured with start.
R_Addr_B  in  ADDR_W  source register for operand B; captured with start.
W_Addr  in  ADDR_W  destination register; captured with start.
OP_in  in  3  ALU opcode; captured with start.
init_we  in  1  external preload write enable; honoured only in IDLE.
init_addr  in  ADDR_W  preload address.
init_data  in  DATA_W  preload data.
A  out  DATA_W  operand A to ALU (registered).
B  out  DATA_W  operand B to ALU (registered).
ALU_OP  out  3  opcode to ALU (registered).
F  in  DATA_W  ALU result.
ZF  in  1  ALU zero flag.
OF  in  1  ALU overflow flag.
F_q  out  DATA_W  last captured result.
ZF_q  out  1  last captured zero flag.
OF_q  out  1  last captured overflow flag.
busy  out  1  high in LOAD, EXEC and WB.
done  out  1  one-cycle pulse after write-back.
DBG_Addr  in  ADDR_W  debug read address.
DBG_Data  out  DATA_W  combinational read of register DBG_Addr (r0 -> 0).

Behaviour:
Reset:
- On rst_n low (asynchronous), all registers r0..r31 clear to 0.
- A, B, F_q clear to 0; ALU_OP clears to 3'b000; ZF_q, OF_q, busy, done clear to 0; FSM goes to IDLE.
- Reset mid-operation aborts it: no write-back and no done pulse.

FSM states: IDLE, LOAD, EXEC, WB.
- IDLE: on start=1, latch the three addresses and OP_in; go to LOAD.
- LOAD: A <= reg[ra], B <= reg[rb], ALU_OP <= op; go to EXEC. Reads of r0 return 0.
- EXEC: A/B/ALU_OP are held stable a full cycle for the combinational ALU. At the end, F_q <= F, ZF_q <= ZF, OF_q <= OF; go to WB.
- WB: reg[rd] <= F_q unless rd == 0; done <= 1; go to IDLE.

Timing and handshake:
- done is registered and high for exactly the one cycle after the WB edge (first IDLE cycle).
- If start is sampled at edge k, done is high in cycle k+3..k+4.
- busy = (state != IDLE), combinational from state.
- start while busy is ignored and not queued.
- start during the done cycle is accepted (back-to-back operation, 4-cycle issue interval).

Preload port:
- init_we writes init_data to reg[init_addr] on the edge in IDLE only. It is ignored when busy or when init_addr == 0.
- If init_we and start occur in the same IDLE cycle, both take effect; LOAD then reads the newly written value when addresses match.

Other rules:
- A, B and ALU_OP hold their last values in IDLE, so the ALU output stays displayable on LEDs.
- Read-after-write: an operation whose source equals the previous rd sees the written value (WB completes before the next LOAD).
- No arithmetic is performed in this block; flags are taken verbatim from the ALU.

Decomposition:
- Shared package: ALU opcode constants (AND=000, OR=001, XOR=010, XNOR=011, ADD=100, SUB=101, SLT=110, SLL=111), FSM state encoding (2-bit), DATA_W/ADDR_W defaults.
- One sub-module: alu_regfile (2 sync-capture read paths plus a combinational debug read, 1 write port with mux of WB/preload, r0 forced zero, async-low reset).

Test Plan:
- Preload r1=0x00000003, r2=0x00000607; start ra=1, rb=2, rd=3, op=100 -> done 3 cycles after start edge, r3=0x0000060A, ZF_q=0, OF_q=0.
- Preload r4=0x7FFFFFFF; start ra=4, rb=4, rd=5, op=100 -> F_q=0xFFFFFFFE, OF_q=1, r5=0xFFFFFFFE.
- start ra=1, rb=1, rd=6, op=010 -> F_q=0, ZF_q=1, r6=0; then rd=0 op=001 -> DBG_Data for addr 0 stays 0.
- Back-to-back: op1 rd=7 = r1+r2, start again in done cycle with ra=7, rb=1, op=101 -> r8=0x00000607. A second start pulsed during busy produces no extra done.
- Same-cycle init_we (r9=0x12345678) and start ra=9, rb=0, op=001, rd=10 -> r10=0x12345678. init_we during busy -> target register unchanged.
- Assert rst_n low during EXEC -> busy=0, done never pulses, all registers read 0, A=B=0 after release.
